note_hit_scorer: RTL and testbench
==================================

NOTE_HIT_SCORER -- requirements
Module: note_hit_scorer

Interface
REQ-001 Parameter HOLD_MIN, default 4: consecutive matching cycles required for a hit.
REQ-002 Parameter SCORE_W, default 16: width of score output.
REQ-003 clk  input  1  system clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 tempo_in  input  26  beat period minus one, in clk cycles.
REQ-006 next_notes  input  64  16-note window; bits [3:0] are the current note. 0 = rest, 15 = end marker, 1..14 = pitch.
REQ-007 song_done  input  1  high when the current note is the end marker.
REQ-008 played_note  input  4  pitch detected from the player.
REQ-009 played_valid  input  1  played_note is meaningful this cycle.
REQ-010 score  output  SCORE_W  accumulated points, saturating.
REQ-011 streak  output  8  consecutive hits, saturating at 255.
REQ-012 max_streak  output  8  largest streak reached this song.
REQ-013 hits, misses  output  10 each  judged-note counters, saturating at 1023.
REQ-014 judge_valid  output  1  one-cycle pulse when a note is judged.
REQ-015 judge_hit  output  1  result of the last judgement; held until the next judgement.
REQ-016 state_out  output  2  current state: 00 IDLE, 01 PLAY, 10 DONE.

Function
REQ-017 The beat counter shall increment every cycle.
- When count >= tempo_in, the cycle is a beat cycle and count clears to 0.
- Period is tempo_in+1 cycles; tempo_in=0 gives a beat every cycle.
REQ-018 State IDLE -> PLAY on the first beat cycle with next_notes[3:0] != 0.
- PLAY -> DONE on any cycle with song_done=1.
- DONE holds until reset.
REQ-019 Match cycle: PLAY, not a beat cycle, played_valid=1, played_note == next_notes[3:0], and next_notes[3:0] in 1..14.
REQ-020 Hold counter: increments on a match cycle, clears on a non-match cycle, saturates at HOLD_MIN. When it reaches HOLD_MIN, the sticky hit_flag sets.
REQ-021 On a beat cycle in PLAY with next_notes[3:0] in 1..14, judge using hit_flag as registered before that cycle.
- Hit: hits+1, streak+1, score+points, judge_hit=1.
- Miss: misses+1, streak=0, judge_hit=0.
- judge_valid pulses on the following cycle (latency 1), when outputs are already updated.
REQ-022 Beat cycles with note 0 or 15 shall produce no judgement, no pulse, and no counter change.
REQ-023 Every beat cycle shall clear the hold counter and hit_flag. Input samples on the beat cycle are discarded.
REQ-024 max_streak updates on the same edge as streak when the new streak exceeds it.
REQ-025 score saturates at 2^SCORE_W-1; streak, hits and misses saturate at their maxima and never wrap.
REQ-026 When song_done rises on a beat cycle, the judgement of that beat is still performed; DONE is entered on the same edge.
REQ-027 In IDLE and DONE: no judgements; all counters and outputs frozen; the beat counter keeps running.

Reset
REQ-028 Reset shall clear to 0 on the next edge: state (IDLE), beat count, hold counter, hit_flag, score, streak, max_streak, hits, misses, judge_valid, judge_hit.
REQ-029 Reset mid-beat or mid-song shall abort the pending judgement with no pulse. Reset has priority over all other events.

Configuration
REQ-030 Macro NOTE_SCORER_STREAK_BONUS_EN.
- Defined: points = 10, 20, 30 or 40 for pre-hit streak values 0-7, 8-15, 16-23 or >=24 respectively.
- Undefined: points = 10 for every hit.
- All other behaviour is identical in both builds.

Verification (tempo_in=9, HOLD_MIN=4)
REQ-031 Note 5 on [3:0]; play 5 with valid for 6 cycles mid-beat.
-> Pulse with judge_hit=1, score=10, streak=1, hits=1.
REQ-032 Note 5; play 5 for 3 cycles, 1 cycle of 6, then 5 for 3 cycles.
-> Miss: misses=1, streak=0, score unchanged.
REQ-033 Ten consecutive hit beats with the macro defined.
-> score=120, streak=10, max_streak=10. Without the macro: score=100.
REQ-034 Streak 3, then a miss, then 2 hits.
-> streak=2, max_streak=3. Rest beats in between produce no pulse and no counter change.
REQ-035 song_done asserted on a hit beat.
-> That judgement counts, state=DONE, and further matching play leaves all outputs frozen.
REQ-036 Reset asserted 5 cycles into a beat with hit_flag set.
-> All outputs 0 next cycle, state IDLE, no judge_valid pulse.

Source files
------------

// File: rtl/note_hit_scorer.sv
// rtl/note_hit_scorer.sv - rhythm-game note judge: beat timing, hold detection, scoring.
// Optional streak bonus scoring enabled by defining NOTE_SCORER_STREAK_BONUS_EN.
module note_hit_scorer #(
    parameter int HOLD_MIN = 4,
    parameter int SCORE_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [25:0]        tempo_in,
    input  logic [63:0]        next_notes,
    input  logic               song_done,
    input  logic [3:0]         played_note,
    input  logic               played_valid,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         streak,
    output logic [7:0]         max_streak,
    output logic [9:0]         hits,
    output logic [9:0]         misses,
    output logic               judge_valid,
    output logic               judge_hit,
    output logic [1:0]         state_out
);
    localparam int HOLD_W = $clog2(HOLD_MIN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [25:0]         beat_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                hit_flag;
    logic [3:0]          cur_note;
    logic                beat;
    logic                is_pitch;
    logic                match;
    logic                judge;
    logic [5:0]          points;
    logic [SCORE_W:0]    score_sum;
    logic [7:0]          streak_inc;
    logic                unused_notes;

    // Only the current note drives judging; the look-ahead window is for display logic elsewhere.
    assign unused_notes = ^next_notes[63:4];

    assign cur_note   = next_notes[3:0];
    assign beat       = beat_cnt >= tempo_in;
    assign is_pitch   = (cur_note != 4'h0) && (cur_note != 4'hf);
    assign match      = (state == PLAY) && !beat && played_valid
                        && (played_note == cur_note) && is_pitch;
    assign judge      = (state == PLAY) && beat && is_pitch;
    assign streak_inc = (streak == 8'hff) ? 8'hff : streak + 8'd1;
    assign state_out  = state;

`ifdef NOTE_SCORER_STREAK_BONUS_EN
    always_comb begin
        points = 6'd40;
        if (streak < 8'd8)
            points = 6'd10;
        else if (streak < 8'd16)
            points = 6'd20;
        else if (streak < 8'd24)
            points = 6'd30;
    end
`else
    assign points = 6'd10;
`endif

    assign score_sum = {1'b0, score} + (SCORE_W + 1)'(points);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (beat && cur_note != 4'h0) state_nx = PLAY;
            PLAY:    if (song_done) state_nx = DONE;
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt    <= '0;
            hold_cnt    <= '0;
            hit_flag    <= 1'b0;
            score       <= '0;
            streak      <= '0;
            max_streak  <= '0;
            hits        <= '0;
            misses      <= '0;
            judge_valid <= 1'b0;
            judge_hit   <= 1'b0;
        end else begin
            beat_cnt    <= beat ? 26'd0 : beat_cnt + 26'd1;
            judge_valid <= judge;

            // Samples on the beat cycle belong to neither note, so the hold window restarts.
            if (beat) begin
                hold_cnt <= '0;
                hit_flag <= 1'b0;
            end else if (match) begin
                if (hold_cnt != HOLD_W'(HOLD_MIN))
                    hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt >= HOLD_W'(HOLD_MIN - 1))
                    hit_flag <= 1'b1;
            end else begin
                hold_cnt <= '0;
            end

            if (judge) begin
                judge_hit <= hit_flag;
                if (hit_flag) begin
                    if (hits != 10'h3ff)
                        hits <= hits + 10'd1;
                    streak <= streak_inc;
                    if (streak_inc > max_streak)
                        max_streak <= streak_inc;
                    score <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
                end else begin
                    if (misses != 10'h3ff)
                        misses <= misses + 10'd1;
                    streak <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_note_hit_scorer.sv
// tb/tb_note_hit_scorer.sv - randomized and directed bench for note_hit_scorer against a behavioural model.
module tb_note_hit_scorer;
    localparam int HOLD_MIN = 4;
    localparam int SCORE_W  = 16;
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [25:0]        tempo_in = 26'd9;
    logic [63:0]        next_notes = '0;
    logic               song_done = 1'b0;
    logic [3:0]         played_note = '0;
    logic               played_valid = 1'b0;
    logic [SCORE_W-1:0] score;
    logic [7:0]         streak;
    logic [7:0]         max_streak;
    logic [9:0]         hits;
    logic [9:0]         misses;
    logic               judge_valid;
    logic               judge_hit;
    logic [1:0]         state_out;

    int errors = 0;
    int checks = 0;

    note_hit_scorer #(.HOLD_MIN(HOLD_MIN), .SCORE_W(SCORE_W)) dut (
        .clk(clk), .reset(reset), .tempo_in(tempo_in), .next_notes(next_notes),
        .song_done(song_done), .played_note(played_note), .played_valid(played_valid),
        .score(score), .streak(streak), .max_streak(max_streak), .hits(hits),
        .misses(misses), .judge_valid(judge_valid), .judge_hit(judge_hit),
        .state_out(state_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: game rules in plain integers.
    int m_on = 0;
    int m_phase, m_state, m_run, m_flag;
    int m_score, m_streak, m_max, m_hits, m_misses, m_jv, m_jh;

    function automatic int bonus_points(input int pre_streak);
`ifdef NOTE_SCORER_STREAK_BONUS_EN
        return (pre_streak >= 24) ? 40 : 10 * (pre_streak / 8 + 1);
`else
        return 10 + 0 * pre_streak;
`endif
    endfunction

    task automatic model_step();
        int  note;
        bit  on_beat, pitch, playing;
        note    = int'(next_notes[3:0]);
        on_beat = (m_phase >= int'(tempo_in));
        pitch   = (note >= 1 && note <= 14);
        playing = (m_state == 1);
        if (reset) begin
            m_on = 1;
            {m_phase, m_state, m_run, m_flag} = '0;
            {m_score, m_streak, m_max, m_hits, m_misses, m_jv, m_jh} = '0;
        end else begin
            m_jv = (playing && on_beat && pitch) ? 1 : 0;
            if (m_jv == 1) begin
                m_jh = m_flag;
                if (m_flag == 1) begin
                    m_score  = (m_score + bonus_points(m_streak) > SCORE_MAX) ? SCORE_MAX
                             : m_score + bonus_points(m_streak);
                    m_streak = (m_streak < 255) ? m_streak + 1 : 255;
                    m_hits   = (m_hits < 1023) ? m_hits + 1 : 1023;
                    if (m_streak > m_max) m_max = m_streak;
                end else begin
                    m_streak = 0;
                    m_misses = (m_misses < 1023) ? m_misses + 1 : 1023;
                end
            end
            if (on_beat) begin
                m_run  = 0;
                m_flag = 0;
            end else if (playing && pitch && played_valid && int'(played_note) == note) begin
                m_run = m_run + 1;
                if (m_run >= HOLD_MIN) m_flag = 1;
            end else begin
                m_run = 0;
            end
            if (m_state == 0 && on_beat && note != 0) m_state = 1;
            else if (m_state == 1 && song_done) m_state = 2;
            m_phase = on_beat ? 0 : m_phase + 1;
        end
    endtask

    always @(posedge clk) begin
        model_step();
        #1;
        if (m_on == 1) begin
            chk("score", score, m_score);
            chk("streak", streak, m_streak);
            chk("max_streak", max_streak, m_max);
            chk("hits", hits, m_hits);
            chk("misses", misses, m_misses);
            chk("judge_valid", judge_valid, m_jv);
            chk("judge_hit", judge_hit, m_jh);
            chk("state_out", state_out, m_state);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        played_valid = 1'b0;
        song_done = 1'b0;
        @(posedge clk);
    endtask

    // One full beat period; cycle k plays `note` if play_mask[k], `alt` if alt_mask[k].
    task automatic run_beat(input logic [3:0] note, input logic [15:0] play_mask,
                            input logic [15:0] alt_mask, input logic [3:0] alt,
                            input bit done_on_beat);
        logic [63:0] upper;
        for (int k = 0; k <= int'(tempo_in); k++) begin
            @(negedge clk);
            reset = 1'b0;
            upper = {$urandom, $urandom};
            next_notes = {upper[63:4], note};
            played_valid = play_mask[k] | alt_mask[k];
            played_note = alt_mask[k] ? alt : note;
            song_done = done_on_beat && (k == int'(tempo_in));
            @(posedge clk);
        end
    endtask

    initial begin
        logic [3:0] rnote;
        logic [63:0] upper;

        // Hit after six matching cycles.
        tempo_in = 26'd9;
        do_reset();
        #1;
        chk("reset_state", state_out, 0);
        chk("reset_score", score, 0);
        run_beat(4'd5, 16'h0000, 16'h0000, 4'd0, 1'b0);
        #1 chk("entry_no_pulse", judge_valid, 0);
        run_beat(4'd5, 16'h00fc, 16'h0000, 4'd0, 1'b0);
        #1;
        chk("t1_pulse", judge_valid, 1);
        chk("t1_hit", judge_hit, 1);
        chk("t1_score", score, 10);
        chk("t1_streak", streak, 1);
        chk("t1_hits", hits, 1);

        // Interrupted hold: two runs of three never reach HOLD_MIN.
        do_reset();
        run_beat(4'd5, 16'h0000, 16'h0000, 4'd0, 1'b0);
        run_beat(4'd5, 16'h00ee, 16'h0010, 4'd6, 1'b0);
        #1;
        chk("t2_pulse", judge_valid, 1);
        chk("t2_hit", judge_hit, 0);
        chk("t2_misses", misses, 1);
        chk("t2_streak", streak, 0);
        chk("t2_score", score, 0);

        // Ten hits in a row.
        do_reset();
        run_beat(4'd5, 16'h0000, 16'h0000, 4'd0, 1'b0);
        for (int i = 0; i < 10; i++) run_beat(4'd5, 16'h00fc, 16'h0000, 4'd0, 1'b0);
        #1;
`ifdef NOTE_SCORER_STREAK_BONUS_EN
        chk("t3_score", score, 120);
`else
        chk("t3_score", score, 100);
`endif
        chk("t3_streak", streak, 10);
        chk("t3_max", max_streak, 10);

        // Streak 3, rest, miss, two hits.
        do_reset();
        run_beat(4'd5, 16'h0000, 16'h0000, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) run_beat(4'd5, 16'h00fc, 16'h0000, 4'd0, 1'b0);
        run_beat(4'd0, 16'h00fc, 16'h0000, 4'd0, 1'b0);
        #1;
        chk("t4_rest_pulse", judge_valid, 0);
        chk("t4_rest_hits", hits, 3);
        run_beat(4'd7, 16'h0000, 16'h0000, 4'd0, 1'b0);
        run_beat(4'd7, 16'h00fc, 16'h0000, 4'd0, 1'b0);
        run_beat(4'd7, 16'h00fc, 16'h0000, 4'd0, 1'b0);
        #1;
        chk("t4_streak", streak, 2);
        chk("t4_max", max_streak, 3);
        chk("t4_misses", misses, 1);

        // song_done on a hit beat, then frozen.
        do_reset();
        run_beat(4'd5, 16'h0000, 16'h0000, 4'd0, 1'b0);
        run_beat(4'd5, 16'h00fc, 16'h0000, 4'd0, 1'b1);
        #1;
        chk("t5_pulse", judge_valid, 1);
        chk("t5_hits", hits, 1);
        chk("t5_state", state_out, 2);
        run_beat(4'd5, 16'h00fc, 16'h0000, 4'd0, 1'b0);
        #1;
        chk("t5_frozen_hits", hits, 1);
        chk("t5_frozen_score", score, 10);
        chk("t5_frozen_pulse", judge_valid, 0);

        // Reset five cycles into a beat with hit_flag already set.
        do_reset();
        run_beat(4'd5, 16'h0000, 16'h0000, 4'd0, 1'b0);
        run_beat(4'd5, 16'h00fc, 16'h0000, 4'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            played_valid = 1'b1;
            played_note = 4'd5;
            @(posedge clk);
        end
        do_reset();
        #1;
        chk("t6_score", score, 0);
        chk("t6_hits", hits, 0);
        chk("t6_streak", streak, 0);
        chk("t6_max", max_streak, 0);
        chk("t6_state", state_out, 0);
        chk("t6_pulse", judge_valid, 0);
        run_beat(4'd0, 16'h0000, 16'h0000, 4'd0, 1'b0);

        // Randomized segments with assorted tempos, including a beat every cycle.
        for (int seg = 0; seg < 8; seg++) begin
            tempo_in = (seg == 0) ? 26'd0 : 26'($urandom_range(1, 7));
            do_reset();
            rnote = 4'd3;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                reset = ($urandom_range(0, 499) == 0);
                if ($urandom_range(0, 5) == 0) begin
                    case ($urandom_range(0, 9))
                        0:       rnote = 4'd0;
                        1:       rnote = 4'd15;
                        default: rnote = 4'($urandom_range(1, 4));
                    endcase
                end
                upper = {$urandom, $urandom};
                next_notes = {upper[63:4], rnote};
                played_valid = ($urandom_range(0, 4) != 0);
                played_note = ($urandom_range(0, 3) != 0) ? rnote : 4'($urandom_range(0, 15));
                song_done = ($urandom_range(0, 299) == 0);
                @(posedge clk);
            end
        end

        // Long all-hit song to drive every counter into saturation.
        tempo_in = 26'd4;
        do_reset();
        run_beat(4'd5, 16'h0000, 16'h0000, 4'd0, 1'b0);
        for (int i = 0; i < 6700; i++) run_beat(4'd5, 16'h000f, 16'h0000, 4'd0, 1'b0);
        #1;
        chk("sat_score", score, SCORE_MAX);
        chk("sat_streak", streak, 255);
        chk("sat_max", max_streak, 255);
        chk("sat_hits", hits, 1023);
        chk("sat_misses", misses, 0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
